// File: rtl/bayer_frame_gen.sv
// -----------------------------------------------------------------------------
// bayer_frame_gen
//
// Deterministic raw Bayer frame source. It stands in for the camera capture
// path and produces a 12-bit pixel stream with coordinates in the form that
// image_proc consumes.
//
// Handshake: there is no back-pressure. A pixel is transferred on every cycle
// where oDVAL is high. oDATA, oX_Cont and oY_Cont always describe the same
// pixel on the same cycle. iSTART and iSTOP are sampled on the rising edge of
// iCLK, and iSTOP is held internally as a sticky request.
//
// Ports
//   iCLK        pixel clock, rising edge
//   iRST        asynchronous, active-high reset
//   iSTART      start streaming when sampled high in IDLE
//   iSTOP       finish the current frame, then return to IDLE (sticky)
//   iMODE       pattern: 0 ramp, 1 colour bars, 2 constant, 3 checker
//   iCONST      pixel value used by mode 2
//   oDATA       raw pixel (0 when not valid)
//   oDVAL       pixel valid
//   oX_Cont     column of the current pixel (0 outside ACTIVE)
//   oY_Cont     row of the current pixel (held through HBLANK)
//   oFVAL       frame active (ACTIVE or HBLANK)
//   oFrame_Cont completed-frame counter, wraps
//   oBUSY       state is not IDLE
//   oState      debug view of the FSM state encoding
// -----------------------------------------------------------------------------
module bayer_frame_gen #(
  parameter int H_ACTIVE = 1280,
  parameter int V_ACTIVE = 960,
  parameter int H_BLANK  = 16,
  parameter int V_BLANK  = 4,
  parameter int STARTUP  = 2
) (
  input  logic        iCLK,
  input  logic        iRST,
  input  logic        iSTART,
  input  logic        iSTOP,
  input  logic [1:0]  iMODE,
  input  logic [11:0] iCONST,
  output logic [11:0] oDATA,
  output logic        oDVAL,
  output logic [10:0] oX_Cont,
  output logic [10:0] oY_Cont,
  output logic        oFVAL,
  output logic [15:0] oFrame_Cont,
  output logic        oBUSY,
  output logic [2:0]  oState
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_STARTUP = 3'd1,
    S_ACTIVE  = 3'd2,
    S_HBLANK  = 3'd3,
    S_VBLANK  = 3'd4
  } state_t;

  // One shared phase counter covers STARTUP, HBLANK and VBLANK.
  localparam int CNT_M1  = (STARTUP > H_BLANK) ? STARTUP : H_BLANK;
  localparam int CNT_MAX = (CNT_M1 > V_BLANK) ? CNT_M1 : V_BLANK;
  localparam int CW      = $clog2(CNT_MAX + 1);

  // STARTUP runs counts 0..STARTUP so that the first pixel appears after
  // edge n+STARTUP+1 when iSTART is sampled at edge n.
  localparam logic [CW-1:0] SU_END = CW'(STARTUP);
  localparam logic [CW-1:0] HB_END = CW'(H_BLANK - 1);
  localparam logic [CW-1:0] VB_END = CW'(V_BLANK - 1);
  localparam logic [10:0]   X_LAST = 11'(H_ACTIVE - 1);
  localparam logic [10:0]   Y_LAST = 11'(V_ACTIVE - 1);

  state_t          state;
  state_t          stateNext;
  logic [CW-1:0]   cnt;
  logic [CW-1:0]   cntNext;
  logic            stopReq;
  logic            stopNext;
  logic [1:0]      modeSh;
  logic [11:0]     constSh;

  logic            latch;
  logic            dvalNext;
  logic [10:0]     xNext;
  logic [10:0]     yNext;
  logic            frameInc;
  logic [1:0]      modeEff;
  logic [11:0]     constEff;
  logic [2:0]      bar;
  logic [1:0]      site;
  logic [11:0]     dataNext;

  assign oState = state;

  // Next-state logic. Outputs are registered from the *next* pixel position,
  // so every decision here is made about the cycle currently on the outputs.
  always_comb begin
    stateNext = state;
    cntNext   = cnt;
    stopNext  = stopReq;
    latch     = 1'b0;
    dvalNext  = 1'b0;
    xNext     = 11'd0;
    yNext     = oY_Cont;

    case (state)
      S_IDLE: begin
        yNext = 11'd0;
        if (iSTART) begin
          stateNext = S_STARTUP;
          cntNext   = '0;
          latch     = 1'b1;
          // Start wins over a simultaneous stop, but the stop is remembered.
          stopNext  = iSTOP;
        end
      end

      S_STARTUP: begin
        yNext = 11'd0;
        if (iSTOP) stopNext = 1'b1;
        if (cnt == SU_END) begin
          stateNext = S_ACTIVE;
          cntNext   = '0;
          dvalNext  = 1'b1;
        end else begin
          cntNext = cnt + CW'(1);
        end
      end

      S_ACTIVE: begin
        if (iSTOP) stopNext = 1'b1;
        if (oX_Cont == X_LAST) begin
          stateNext = S_HBLANK;
          cntNext   = '0;
        end else begin
          dvalNext = 1'b1;
          xNext    = oX_Cont + 11'd1;
        end
      end

      S_HBLANK: begin
        if (iSTOP) stopNext = 1'b1;
        if (cnt == HB_END) begin
          cntNext = '0;
          if (oY_Cont < Y_LAST) begin
            stateNext = S_ACTIVE;
            dvalNext  = 1'b1;
            yNext     = oY_Cont + 11'd1;
          end else begin
            stateNext = S_VBLANK;
            yNext     = 11'd0;
          end
        end else begin
          cntNext = cnt + CW'(1);
        end
      end

      S_VBLANK: begin
        yNext = 11'd0;
        if (iSTOP) stopNext = 1'b1;
        if (cnt == VB_END) begin
          cntNext = '0;
          // A stop seen on the final VBLANK cycle still ends the stream here.
          if (stopReq || iSTOP) begin
            stateNext = S_IDLE;
            stopNext  = 1'b0;
          end else begin
            stateNext = S_ACTIVE;
            dvalNext  = 1'b1;
            latch     = 1'b1;
          end
        end else begin
          cntNext = cnt + CW'(1);
        end
      end

      default: begin
        stateNext = S_IDLE;
        cntNext   = '0;
        stopNext  = 1'b0;
        yNext     = 11'd0;
      end
    endcase

    frameInc = dvalNext && (xNext == X_LAST) && (yNext == Y_LAST);
  end

  // Pattern generator. On a latch cycle the first pixel must already use the
  // newly sampled mode/const, so the live inputs bypass the shadow registers.
  always_comb begin
    modeEff  = latch ? iMODE : modeSh;
    constEff = latch ? iCONST : constSh;
    bar      = xNext[9:7];
    site     = {yNext[0], xNext[0]};
    dataNext = 12'd0;
    if (dvalNext) begin
      case (modeEff)
        2'd0: dataNext = {1'b0, xNext} + {1'b0, yNext};
        2'd1: begin
          case (site)
            2'b01:   dataNext = bar[0] ? 12'hFFF : 12'h000;  // R
            2'b10:   dataNext = bar[2] ? 12'hFFF : 12'h000;  // B
            default: dataNext = bar[1] ? 12'hFFF : 12'h000;  // G
          endcase
        end
        2'd2:    dataNext = constEff;
        default: dataNext = (xNext[3] ^ yNext[3]) ? 12'hFFF : 12'h000;
      endcase
    end
  end

  always_ff @(posedge iCLK or posedge iRST) begin
    if (iRST) begin
      state       <= S_IDLE;
      cnt         <= '0;
      stopReq     <= 1'b0;
      modeSh      <= 2'd0;
      constSh     <= 12'd0;
      oDATA       <= 12'd0;
      oDVAL       <= 1'b0;
      oX_Cont     <= 11'd0;
      oY_Cont     <= 11'd0;
      oFVAL       <= 1'b0;
      oFrame_Cont <= 16'd0;
      oBUSY       <= 1'b0;
    end else begin
      state       <= stateNext;
      cnt         <= cntNext;
      stopReq     <= stopNext;
      if (latch) begin
        modeSh  <= iMODE;
        constSh <= iCONST;
      end
      oDATA       <= dataNext;
      oDVAL       <= dvalNext;
      oX_Cont     <= xNext;
      oY_Cont     <= yNext;
      oFVAL       <= (stateNext == S_ACTIVE) || (stateNext == S_HBLANK);
      oFrame_Cont <= oFrame_Cont + {15'd0, frameInc};
      oBUSY       <= (stateNext != S_IDLE);
    end
  end

endmodule

// File: tb/tb_bayer_frame_gen.sv
// -----------------------------------------------------------------------------
// tb_bayer_frame_gen
//
// Directed bench for bayer_frame_gen. A small instance (4x3 frame) carries the
// timing, reset, stop and pattern-latch cases; a default-size instance checks
// the colour-bar sites.
// -----------------------------------------------------------------------------
module tb_bayer_frame_gen;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time limit reached before summary");
    $fatal(1, "watchdog");
  end

  // ---------------- small DUT ----------------
  logic        sStart = 1'b0, sStop = 1'b0;
  logic [1:0]  sMode  = 2'd0;
  logic [11:0] sConst = 12'd0;
  logic [11:0] sData;
  logic        sDval, sFval, sBusy;
  logic [10:0] sX, sY;
  logic [15:0] sFrame;
  logic [2:0]  sState;

  bayer_frame_gen #(
    .H_ACTIVE(4), .V_ACTIVE(3), .H_BLANK(2), .V_BLANK(3), .STARTUP(2)
  ) u_small (
    .iCLK(clk), .iRST(rst), .iSTART(sStart), .iSTOP(sStop),
    .iMODE(sMode), .iCONST(sConst),
    .oDATA(sData), .oDVAL(sDval), .oX_Cont(sX), .oY_Cont(sY),
    .oFVAL(sFval), .oFrame_Cont(sFrame), .oBUSY(sBusy), .oState(sState)
  );

  // ---------------- default-size DUT ----------------
  logic        bStart = 1'b0, bStop = 1'b0;
  logic [1:0]  bMode  = 2'd1;
  logic [11:0] bConst = 12'd0;
  logic [11:0] bData;
  logic        bDval, bFval, bBusy;
  logic [10:0] bX, bY;
  logic [15:0] bFrame;
  logic [2:0]  bState;

  bayer_frame_gen u_big (
    .iCLK(clk), .iRST(rst), .iSTART(bStart), .iSTOP(bStop),
    .iMODE(bMode), .iCONST(bConst),
    .oDATA(bData), .oDVAL(bDval), .oX_Cont(bX), .oY_Cont(bY),
    .oFVAL(bFval), .oFrame_Cont(bFrame), .oBUSY(bBusy), .oState(bState)
  );

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [11:0] exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  // Advance one clock and land 1ns after the edge, where outputs are sampled
  // and inputs for the next edge are driven.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    #2 rst = 1'b0;
    tick();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic        start;
    logic        dval;
    logic [10:0] x;
    logic [10:0] y;
    logic [11:0] data;
    logic        fval;
    logic        busy;
    logic [15:0] frame;
  } vec_t;

  vec_t vecs[25];

  function automatic vec_t mk(input logic st, input logic dv, input int x, input int y,
                              input int d, input logic fv, input logic bz, input int fr);
    vec_t v;
    v.start = st;
    v.dval  = dv;
    v.x     = 11'(x);
    v.y     = 11'(y);
    v.data  = 12'(d);
    v.fval  = fv;
    v.busy  = bz;
    v.frame = 16'(fr);
    return v;
  endfunction

  // ---------------- test sequence ----------------
  initial begin
    int dvCount;
    int gapDval;
    logic [11:0] got;

    // Ramp frame, one entry per edge after iSTART is sampled (edge 0).
    vecs[0]  = mk(1, 0, 0, 0, 0, 0, 1, 0);
    vecs[1]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    vecs[2]  = mk(0, 0, 0, 0, 0, 0, 1, 0);
    vecs[3]  = mk(0, 1, 0, 0, 0, 1, 1, 0);
    vecs[4]  = mk(0, 1, 1, 0, 1, 1, 1, 0);
    vecs[5]  = mk(0, 1, 2, 0, 2, 1, 1, 0);
    vecs[6]  = mk(0, 1, 3, 0, 3, 1, 1, 0);
    vecs[7]  = mk(0, 0, 0, 0, 0, 1, 1, 0);
    vecs[8]  = mk(0, 0, 0, 0, 0, 1, 1, 0);
    vecs[9]  = mk(0, 1, 0, 1, 1, 1, 1, 0);
    vecs[10] = mk(0, 1, 1, 1, 2, 1, 1, 0);
    vecs[11] = mk(0, 1, 2, 1, 3, 1, 1, 0);
    vecs[12] = mk(0, 1, 3, 1, 4, 1, 1, 0);
    vecs[13] = mk(0, 0, 0, 1, 0, 1, 1, 0);
    vecs[14] = mk(0, 0, 0, 1, 0, 1, 1, 0);
    vecs[15] = mk(0, 1, 0, 2, 2, 1, 1, 0);
    vecs[16] = mk(0, 1, 1, 2, 3, 1, 1, 0);
    vecs[17] = mk(0, 1, 2, 2, 4, 1, 1, 0);
    vecs[18] = mk(0, 1, 3, 2, 5, 1, 1, 1);
    vecs[19] = mk(0, 0, 0, 2, 0, 1, 1, 1);
    vecs[20] = mk(0, 0, 0, 2, 0, 1, 1, 1);
    vecs[21] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    vecs[22] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    vecs[23] = mk(0, 0, 0, 0, 0, 0, 1, 1);
    vecs[24] = mk(0, 1, 0, 0, 0, 1, 1, 1);

    // ---- reset values ----
    tick();
    tick();
    chk("rst_data", sData, 0);
    chk("rst_dval", sDval, 0);
    chk("rst_x", sX, 0);
    chk("rst_y", sY, 0);
    chk("rst_fval", sFval, 0);
    chk("rst_frame", sFrame, 0);
    chk("rst_busy", sBusy, 0);
    #2 rst = 1'b0;
    tick();
    chk("idle_state", sState, 0);

    // ---- ramp frame from table ----
    sMode = 2'd0;
    for (int i = 0; i < 25; i++) begin
      sStart = vecs[i].start;
      tick();
      chk($sformatf("ramp[%0d].dval", i), sDval, vecs[i].dval);
      chk($sformatf("ramp[%0d].x", i), sX, vecs[i].x);
      chk($sformatf("ramp[%0d].y", i), sY, vecs[i].y);
      chk($sformatf("ramp[%0d].data", i), sData, vecs[i].data);
      chk($sformatf("ramp[%0d].fval", i), sFval, vecs[i].fval);
      chk($sformatf("ramp[%0d].busy", i), sBusy, vecs[i].busy);
      chk($sformatf("ramp[%0d].frame", i), sFrame, vecs[i].frame);
    end

    // ---- reset mid-frame at Y=1, X=2 ----
    for (int i = 0; i < 8; i++) tick();
    chk("mid_pre_x", sX, 2);
    chk("mid_pre_y", sY, 1);
    #2 rst = 1'b1;
    #1;
    chk("mid_rst_data", sData, 0);
    chk("mid_rst_dval", sDval, 0);
    chk("mid_rst_x", sX, 0);
    chk("mid_rst_y", sY, 0);
    chk("mid_rst_fval", sFval, 0);
    chk("mid_rst_frame", sFrame, 0);
    chk("mid_rst_busy", sBusy, 0);
    #2 rst = 1'b0;
    for (int i = 0; i < 3; i++) tick();
    chk("post_rst_busy", sBusy, 0);
    chk("post_rst_state", sState, 0);

    // ---- back-to-back frames with iSTART held ----
    do_reset();
    sStart  = 1'b1;
    gapDval = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (c == 18) begin
        chk("b2b_f1_last_dval", sDval, 1);
        chk("b2b_f1_last_data", sData, 5);
        chk("b2b_f1_last_frame", sFrame, 1);
      end
      if (c >= 19 && c <= 23 && sDval) gapDval++;
      if (c == 24) begin
        chk("b2b_f2_first_dval", sDval, 1);
        chk("b2b_f2_first_xy", {sX, sY}, 0);
      end
      if (c == 39) begin
        chk("b2b_f2_last_dval", sDval, 1);
        chk("b2b_f2_last_data", sData, 5);
        chk("b2b_f2_last_frame", sFrame, 2);
      end
    end
    chk("b2b_gap_dval", gapDval, 0);
    sStart = 1'b0;
    sStop  = 1'b1;
    tick();
    sStop = 1'b0;
    for (int c = 0; c < 60 && sBusy; c++) tick();
    chk("b2b_stop_busy", sBusy, 0);

    // ---- stop pulsed during row 0 ----
    do_reset();
    dvCount = 0;
    for (int c = 0; c < 40; c++) begin
      sStart = (c == 0);
      sStop  = (c == 4);
      tick();
      if (sDval) dvCount++;
      if (c == 23) chk("stop_busy_last_vblank", sBusy, 1);
      if (c == 24) begin
        chk("stop_busy_fall", sBusy, 0);
        chk("stop_state_idle", sState, 0);
      end
    end
    sStop = 1'b0;
    chk("stop_pixel_count", dvCount, 12);
    chk("stop_frame_count", sFrame, 1);
    chk("stop_still_idle", sBusy, 0);

    // ---- pattern stability: const frame, then checker ----
    do_reset();
    for (int i = 0; i < 12; i++) exp_q.push_back(12'hABC);
    for (int i = 0; i < 12; i++) exp_q.push_back(12'h000);
    sMode  = 2'd2;
    sConst = 12'hABC;
    for (int c = 0; c < 55; c++) begin
      sStart = (c == 0);
      sStop  = (c == 26);
      if (c == 8) begin
        sMode  = 2'd3;
        sConst = 12'h123;
      end
      tick();
      if (sDval) begin
        if (exp_q.size() == 0) begin
          chk("pat_extra_pixel", 1, 0);
        end else begin
          got = exp_q.pop_front();
          chk($sformatf("pat_pixel_c%0d", c), sData, got);
        end
      end
    end
    sStop = 1'b0;
    chk("pat_queue_drained", exp_q.size(), 0);
    chk("pat_frame_count", sFrame, 2);
    chk("pat_idle", sBusy, 0);

    // ---- colour bars on default-size instance ----
    // Pixel (x,y) appears after edge 3 + y*1296 + x.
    bMode = 2'd1;
    for (int c = 0; c <= 3 + 1296 + 512; c++) begin
      bStart = (c == 0);
      tick();
      if (c == 3) begin
        chk("bars_r0x0", bData, 0);
        chk("bars_r0x0_dval", bDval, 1);
        chk("bars_r0x0_fval", bFval, 1);
      end
      if (c == 4) chk("bars_r0x1", bData, 0);
      if (c == 3 + 128) begin
        chk("bars_r0x128", bData, 0);
        chk("bars_r0x128_x", bX, 128);
      end
      if (c == 3 + 129) chk("bars_r0x129", bData, 12'hFFF);
      if (c == 3 + 1296 + 512) begin
        chk("bars_r1x512", bData, 12'hFFF);
        chk("bars_r1x512_xy", {bX, bY}, {11'd512, 11'd1});
        chk("bars_frame", bFrame, 0);
        chk("bars_busy", bBusy, 1);
        chk("bars_state", bState, 2);
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
